// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e      : responder FSM states (IDLE / WAIT / RESP)
//   WCNT_W       : width of the wait-state counter
//   LATENCY_MAX  : largest wait-state count the counter can represent
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WCNT_W      = 4;
  localparam int unsigned LATENCY_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage array for the data-memory responder.
// Synchronous write, combinational read, no reset (contents survive reset).
//   clk     : write clock
//   we_i    : write enable
//   addr_i  : word index (shared by read and write)
//   wdata_i : write data
//   rdata_o : read data for addr_i
module dmem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter              data_file_name = 0
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the pipeline data-memory load/store interface.
// Services one request at a time, inserts LATENCY wait states, then returns
// a one-cycle response carrying read data and an error flag.
//   clk        : clock
//   rstb       : asynchronous active-high reset
//   req_rd_en  : read request
//   req_wr_en  : write request
//   req_addr   : byte address
//   req_wdata  : write data
//   req_ready  : a request can be accepted this cycle
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : read data, qualified by rsp_valid
//   rsp_err    : illegal access, qualified by rsp_valid
//   access_cnt : saturating count of accepted requests
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2,
  parameter              data_file_name = 0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req_rd_en,
  input  logic                  req_wr_en,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           access_cnt
);

  // Latencies beyond what the wait counter can hold are clamped.
  localparam int unsigned LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [WCNT_W-1:0] WAIT_LOAD =
    (LAT_EFF == 0) ? '0 : WCNT_W'(LAT_EFF - 1);

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  op_rd_q, op_rd_d;
  logic                  op_wr_q, op_wr_d;
  logic                  op_err_q, op_err_d;
  logic [ADDR_WIDTH-1:0] op_idx_q, op_idx_d;
  logic [DATA_WIDTH-1:0] op_wdata_q, op_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  enter_resp;
  logic                  cur_rd, cur_wr, cur_err;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Request decode
  assign accept  = (req_rd_en | req_wr_en) & req_ready;
  assign req_err = (req_rd_en & req_wr_en)
                 | (|req_addr[1:0])
                 | (|req_addr[DATA_WIDTH-1:ADDR_WIDTH+2]);
  assign req_idx = req_addr[ADDR_WIDTH+1:2];

  // RESP is entered either from WAIT when the counter expires, or straight
  // from an accept when there are no wait states. In the latter case the
  // captured operation is not yet registered, so the live request is used.
  assign enter_resp = ((state_q == ST_WAIT) && (wcnt_q == '0))
                    || (accept && (LAT_EFF == 0));

  always_comb begin
    if (state_q == ST_WAIT) begin
      cur_rd    = op_rd_q;
      cur_wr    = op_wr_q;
      cur_err   = op_err_q;
      cur_idx   = op_idx_q;
      cur_wdata = op_wdata_q;
    end else begin
      cur_rd    = req_rd_en;
      cur_wr    = req_wr_en;
      cur_err   = req_err;
      cur_idx   = req_idx;
      cur_wdata = req_wdata;
    end
  end

  assign mem_we = enter_resp & cur_wr & ~cur_err;

  dmem_array #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .data_file_name (data_file_name)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = (LAT_EFF == 0) ? ST_RESP : ST_WAIT;
          wcnt_d  = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q != ST_WAIT);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    rsp_err   = (state_q == ST_RESP) & err_q;
  end

  // Operation capture, response data and access counter
  always_comb begin
    op_rd_d    = op_rd_q;
    op_wr_d    = op_wr_q;
    op_err_d   = op_err_q;
    op_idx_d   = op_idx_q;
    op_wdata_d = op_wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (accept) begin
      op_rd_d    = req_rd_en;
      op_wr_d    = req_wr_en;
      op_err_d   = req_err;
      op_idx_d   = req_idx;
      op_wdata_d = req_wdata;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    if (enter_resp) begin
      rdata_d = (cur_rd & ~cur_err) ? mem_rdata : '0;
      err_d   = cur_err;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      op_err_q   <= 1'b0;
      op_idx_q   <= '0;
      op_wdata_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      op_rd_q    <= op_rd_d;
      op_wr_q    <= op_wr_d;
      op_err_q   <= op_err_d;
      op_idx_q   <= op_idx_d;
      op_wdata_q <= op_wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign access_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Four instances with LATENCY 0, 2,
// 3 and 4 share clock and reset; each is driven independently and checked
// against a word-level reference memory and access counter.
module tb_dmem_responder;

  localparam int NDUT = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rstb;
  logic        rd_en [NDUT];
  logic        wr_en [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  wire  [NDUT-1:0] ready;
  wire  [NDUT-1:0] valid;
  wire  [NDUT-1:0] err;
  wire  [31:0] rdata [NDUT];
  wire  [15:0] cnt   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem   [NDUT][1024];
  bit          ref_known [NDUT][1024];
  int unsigned exp_cnt   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk        (clk),
      .rstb       (rstb),
      .req_rd_en  (rd_en[g]),
      .req_wr_en  (wr_en[g]),
      .req_addr   (addr[g]),
      .req_wdata  (wdata[g]),
      .req_ready  (ready[g]),
      .rsp_valid  (valid[g]),
      .rsp_rdata  (rdata[g]),
      .rsp_err    (err[g]),
      .access_cnt (cnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    rd_en[k] = rd;
    wr_en[k] = wr;
    addr[k]  = a;
    wdata[k] = wd;
  endtask

  // Reference: apply one accepted request to the word-level model.
  task automatic model_accept(input int k, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] er, output logic ee, output bit known);
    int idx;
    idx   = int'(a[11:2]);
    ee    = (rd && wr) || (a[1:0] != 2'd0) || (a[31:12] != 20'd0);
    er    = 32'd0;
    known = 1'b1;
    if (!ee && rd) begin
      known = ref_known[k][idx];
      er    = ref_mem[k][idx];
    end
    if (!ee && wr) begin
      ref_mem[k][idx]   = wd;
      ref_known[k][idx] = 1'b1;
    end
    if (exp_cnt[k] < 32'hFFFF) exp_cnt[k]++;
  endtask

  // Wait (bounded) until ready, then let the next edge accept.
  task automatic wait_accept(input int k);
    int n;
    n = 0;
    while (!ready[k] && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_accept", 32'(ready[k]), 32'd1);
    tick();
  endtask

  // Called in the cycle right after the accepting edge.
  task automatic wait_rsp(input int k, input logic [31:0] er, input logic ee, input bit known);
    int n;
    n = 1;
    while (!valid[k] && n < lat_of(k) + 4) begin
      check("ready_low_in_wait", 32'(ready[k]), 32'd0);
      check("cnt_in_wait", 32'(cnt[k]), exp_cnt[k]);
      tick();
      n++;
    end
    check("rsp_latency", 32'(n), 32'(lat_of(k) + 1));
    check("rsp_valid", 32'(valid[k]), 32'd1);
    check("ready_in_resp", 32'(ready[k]), 32'd1);
    check("rsp_err", 32'(err[k]), 32'(ee));
    if (known) check("rsp_rdata", rdata[k], er);
    check("access_cnt", 32'(cnt[k]), exp_cnt[k]);
  endtask

  task automatic xact(input int k, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er;
    logic        ee;
    bit          kn;
    drive(k, rd, wr, a, wd);
    wait_accept(k);
    model_accept(k, rd, wr, a, wd, er, ee, kn);
    drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(k, er, ee, kn);
    tick();
    check("valid_one_cycle", 32'(valid[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] er, v0, va;
    logic        ee;
    bit          kn;
    logic        rd, wr;
    logic [31:0] a;
    int          r;

    for (int k = 0; k < NDUT; k++) begin
      drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
      exp_cnt[k] = 0;
    end
    rstb = 1'b1;
    #2;
    for (int k = 0; k < NDUT; k++) begin
      check("reset_valid", 32'(valid[k]), 32'd0);
      check("reset_ready", 32'(ready[k]), 32'd1);
      check("reset_rdata", rdata[k], 32'd0);
      check("reset_err",   32'(err[k]), 32'd0);
      check("reset_cnt",   32'(cnt[k]), 32'd0);
    end
    #10 rstb = 1'b0;
    tick();

    // Write then read back, LATENCY 2
    xact(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    xact(1, 1'b1, 1'b0, 32'h10, 32'd0);

    // Illegal accesses, LATENCY 2
    v0 = $urandom;
    xact(1, 1'b0, 1'b1, 32'h0, v0);
    xact(1, 1'b1, 1'b0, 32'h12, 32'd0);
    xact(1, 1'b0, 1'b1, 32'h1000, ~v0);
    xact(1, 1'b1, 1'b1, 32'h4, 32'h12345678);
    xact(1, 1'b1, 1'b0, 32'h0, 32'd0);

    // Back-to-back reads held continuously, LATENCY 0
    for (int i = 0; i < 3; i++) xact(0, 1'b0, 1'b1, 32'(i * 4), $urandom);
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("b2b_ready", 32'(ready[0]), 32'd1);
      tick();
      model_accept(0, 1'b1, 1'b0, 32'(i * 4), 32'd0, er, ee, kn);
      if (i < 2) drive(0, 1'b1, 1'b0, 32'((i + 1) * 4), 32'd0);
      else       drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("b2b_valid", 32'(valid[0]), 32'd1);
      check("b2b_rdata", rdata[0], er);
      check("b2b_cnt",   32'(cnt[0]), exp_cnt[0]);
    end
    tick();
    check("b2b_end", 32'(valid[0]), 32'd0);

    // Request held through WAIT is ignored, then accepted in RESP, LATENCY 3
    xact(2, 1'b0, 1'b1, 32'h40, $urandom);
    drive(2, 1'b1, 1'b0, 32'h40, 32'd0);
    wait_accept(2);
    model_accept(2, 1'b1, 1'b0, 32'h40, 32'd0, er, ee, kn);
    va = $urandom;
    drive(2, 1'b0, 1'b1, 32'h44, va);
    wait_rsp(2, er, ee, kn);
    tick();
    model_accept(2, 1'b0, 1'b1, 32'h44, va, er, ee, kn);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(2, er, ee, kn);
    tick();
    check("held_valid_one_cycle", 32'(valid[2]), 32'd0);
    xact(2, 1'b1, 1'b0, 32'h44, 32'd0);

    // Reset during WAIT discards the pending write, LATENCY 4
    xact(3, 1'b0, 1'b1, 32'h20, $urandom);
    drive(3, 1'b0, 1'b1, 32'h20, 32'h5);
    wait_accept(3);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    #2 rstb = 1'b1;
    #1;
    check("midrst_valid", 32'(valid[3]), 32'd0);
    check("midrst_ready", 32'(ready[3]), 32'd1);
    check("midrst_rdata", rdata[3], 32'd0);
    check("midrst_err",   32'(err[3]), 32'd0);
    check("midrst_cnt",   32'(cnt[3]), 32'd0);
    for (int k = 0; k < NDUT; k++) exp_cnt[k] = 0;
    #4 rstb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("midrst_no_rsp", 32'(valid[3]), 32'd0);
    end
    xact(3, 1'b1, 1'b0, 32'h20, 32'd0);

    // Randomized traffic on every instance
    for (int k = 0; k < NDUT; k++) begin
      for (int t = 0; t < 30; t++) begin
        r  = int'($urandom_range(0, 9));
        rd = 1'($urandom_range(0, 1));
        wr = ~rd;
        if (r == 0) begin
          rd = 1'b1;
          wr = 1'b1;
        end
        a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        if (r == 1) a = a | 32'($urandom_range(1, 3));
        if (r == 2) a = a | (32'd1 << $urandom_range(12, 31));
        xact(k, rd, wr, a, $urandom);
      end
    end

    // Counter saturation, LATENCY 2
    force g_dut[1].u_dut.cnt_q = 16'hFFFE;
    #1;
    release g_dut[1].u_dut.cnt_q;
    #1;
    exp_cnt[1] = 32'hFFFE;
    check("sat_preload", 32'(cnt[1]), exp_cnt[1]);
    for (int i = 0; i < 3; i++) xact(1, 1'b1, 1'b0, 32'h10, 32'd0);
    check("sat_hold", 32'(cnt[1]), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
